// File: rtl/regfile_wr_ctrl.sv
// Write-port arbiter for the register file. The pipeline writeback always
// owns the port when it asks for it; a single long-latency result is parked
// in a one-entry holding buffer and drained on the first free cycle. A
// 32-bit scoreboard tracks destinations whose LU result is still
// outstanding, so decode can stall and issue can avoid WAW hazards. If the
// parked result waits too long, pipe_hold asks the pipeline to leave one
// cycle free.
module regfile_wr_ctrl #(
    parameter int REG_WIDTH = 32,
    parameter int MAX_WAIT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pipe_wr_en,
    input  logic [4:0]           pipe_rd,
    input  logic [REG_WIDTH-1:0] pipe_din,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    output logic                 issue_ready,
    input  logic                 lu_valid,
    input  logic [4:0]           lu_rd,
    input  logic [REG_WIDTH-1:0] lu_din,
    output logic                 lu_ready,
    input  logic [4:0]           chk_rs1,
    input  logic [4:0]           chk_rs2,
    input  logic [4:0]           chk_rd,
    output logic                 stall,
    output logic                 pipe_hold,
    output logic                 rf_reg_write,
    output logic [4:0]           rf_rd,
    output logic [REG_WIDTH-1:0] rf_rd_din,
    output logic                 err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [3:0]           wait_cnt;
    logic [3:0]           wait_cnt_next;
    logic                 err_next;
    logic [31:0]          busy;
    logic [31:0]          busy_next;
    logic [4:0]           buf_rd;
    logic [REG_WIDTH-1:0] buf_din;
    logic                 buf_valid;
    logic                 accept;
    logic                 drain;

    // The buffer is occupied exactly when the FSM is out of EMPTY.
    assign buf_valid   = (state != EMPTY);
    assign lu_ready    = ~buf_valid;
    assign accept      = lu_valid & lu_ready;
    assign drain       = buf_valid & ~pipe_wr_en;
    assign pipe_hold   = (state == FORCE);
    // No bypass: a clear happening this cycle does not free issue yet.
    assign issue_ready = ~busy[issue_rd];
    assign stall       = ((chk_rs1 != 5'd0) & busy[chk_rs1])
                       | ((chk_rs2 != 5'd0) & busy[chk_rs2])
                       | ((chk_rd  != 5'd0) & busy[chk_rd]);

    // Write-port mux: pipeline first, then buffered LU result, else idle zeros.
    always_comb begin
        rf_reg_write = 1'b0;
        rf_rd        = 5'd0;
        rf_rd_din    = '0;
        if (pipe_wr_en) begin
            rf_reg_write = 1'b1;
            rf_rd        = pipe_rd;
            rf_rd_din    = pipe_din;
        end else if (buf_valid) begin
            rf_reg_write = 1'b1;
            rf_rd        = buf_rd;
            rf_rd_din    = buf_din;
        end
    end

    // Scoreboard update: clear on drain, set on accepted issue (x0 never set).
    always_comb begin
        busy_next = busy;
        if (drain) begin
            busy_next[buf_rd] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != 5'd0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Buffer FSM next state, wait counter and sticky protocol error.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        err_next      = err;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next    = WAIT;
                    wait_cnt_next = 4'd0;
                end
            end
            WAIT: begin
                if (drain) begin
                    state_next    = EMPTY;
                    wait_cnt_next = 4'd0;
                end else if (wait_cnt == 4'(MAX_WAIT - 1)) begin
                    state_next = FORCE;
                end else if (wait_cnt != 4'hF) begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            FORCE: begin
                if (drain) begin
                    state_next    = EMPTY;
                    wait_cnt_next = 4'd0;
                end else begin
                    // Pipeline wrote while told to hold: flag it, keep holding.
                    err_next = 1'b1;
                end
            end
            default: begin
                state_next    = EMPTY;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            wait_cnt <= 4'd0;
            err      <= 1'b0;
            busy     <= 32'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            err      <= err_next;
            busy     <= busy_next;
        end
    end

    // Holding-buffer payload; validity lives in the FSM, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_rd  <= lu_rd;
            buf_din <= lu_din;
        end
    end

endmodule

// File: doc/regfile_wr_ctrl.md
Name: regfile_wr_ctrl

Overview:
- Controller for the regfile's single write port (rd/rd_din/reg_write).
- Shares that port between two writers:
  - Pipeline writeback, which has priority and no backpressure.
  - A long-latency unit (LU, e.g. divider or load miss), buffered through a 1-entry holding register.
- Keeps a 32-entry scoreboard of destinations with an LU result still pending, and raises a stall for dependent instructions.
- Starvation guard: if the LU result waits too long, the block asserts pipe_hold to force a drain.

Parameters:
- REG_WIDTH, 32, data width; must match the regfile.
- MAX_WAIT, 4, cycles a buffered LU result may wait before pipe_hold asserts. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pipe_wr_en  in  1  pipeline writeback request
- pipe_rd  in  5  pipeline destination register
- pipe_din  in  REG_WIDTH  pipeline write data
- issue_valid  in  1  LU op issued this cycle
- issue_rd  in  5  LU op destination
- issue_ready  out  1  issue allowed (no WAW on issue_rd)
- lu_valid  in  1  LU result valid
- lu_rd  in  5  LU result destination
- lu_din  in  REG_WIDTH  LU result data
- lu_ready  out  1  holding buffer can accept a result
- chk_rs1, chk_rs2, chk_rd  in  5 each  decode-stage operands to check
- stall  out  1  decode-stage operand is pending
- pipe_hold  out  1  request that the pipeline suppress writeback
- rf_reg_write  out  1  to regfile reg_write
- rf_rd  out  5  to regfile rd
- rf_rd_din  out  REG_WIDTH  to regfile rd_din
- err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async):
  - busy[31:0]=0, buf_valid=0, wait_cnt=0, state=EMPTY.
  - pipe_hold=0, err=0.
  - Combinational outputs at reset: lu_ready=1, stall=0, rf_reg_write=0.
- Scoreboard:
  - Issue handshake: issue_valid & issue_ready sets busy[issue_rd] at the clock edge. issue_rd=0 never sets busy.
  - Drain clears busy[buf_rd] at the clock edge.
  - issue_ready = ~busy[issue_rd]. There is no bypass: a same-cycle clear does not make issue_ready 1.
  - Same-cycle set and clear of different registers are both applied.
  - stall = (chk_rs1≠0 & busy[chk_rs1]) | (chk_rs2≠0 & busy[chk_rs2]) | (chk_rd≠0 & busy[chk_rd]). Purely combinational.
- LU buffer:
  - lu_ready = ~buf_valid.
  - A handshake (lu_valid & lu_ready) captures lu_rd/lu_din; buf_valid=1 from the next cycle.
  - A result is never written to the regfile in its acceptance cycle, so minimum accept-to-write latency is 1 cycle.
- Write-port mux (combinational):
  - If pipe_wr_en=1: the pipeline owns the port. rf_reg_write=1, rf_rd=pipe_rd, rf_rd_din=pipe_din. This holds even for pipe_rd=0; the regfile ignores x0.
  - Else if buf_valid=1: drain. rf_reg_write=1, rf_rd=buf_rd, rf_rd_din=buf_din. buf_valid and busy[buf_rd] clear at the edge.
  - Else: rf_reg_write=0; rf_rd and rf_rd_din are 0.
- A buffered result to x0 drains normally (regfile drops it).
- FSM, evaluated at each edge:
  - EMPTY:
    - Handshake → WAIT, wait_cnt=0.
  - WAIT (buf_valid=1, pipe_hold=0):
    - Drain → EMPTY.
    - No drain and wait_cnt=MAX_WAIT-1 → FORCE, pipe_hold=1.
    - Otherwise wait_cnt+1.
  - FORCE (pipe_hold=1):
    - The pipeline contract is pipe_wr_en=0 while pipe_hold=1, so the drain occurs this cycle.
    - → EMPTY; pipe_hold=0 and wait_cnt=0 next cycle.
  - A new handshake in the drain cycle is impossible (lu_ready=0 while buf_valid=1).
- pipe_wr_en=1 while pipe_hold=1:
  - The pipeline still wins the port.
  - err sets and stays set until reset.
  - State stays FORCE.
- Reset mid-operation discards the buffered result and clears all busy bits. The LU must also be reset.
- wait_cnt is 4 bits and saturates; no wrap.

Test Plan:
- Reset, then idle 5 cycles → lu_ready=1, stall=0, issue_ready=1, pipe_hold=0, rf_reg_write=0, err=0.
- Issue rd=5; then chk_rs1=5 → stall=1. Next cycle, issue rd=5 again → issue_ready=0. lu_valid rd=5 din=0xDEADBEEF with pipe_wr_en=0 → next cycle rf_reg_write=1, rf_rd=5, rf_rd_din=0xDEADBEEF. One cycle later stall=0 and issue_ready=1.
- Buffered LU result rd=7 while pipe_wr_en=1 (rd=3, 0x11) every cycle, MAX_WAIT=4 → pipeline writes rd=3 each cycle. pipe_hold=1 exactly 4 cycles after buf_valid rose. With pipe_wr_en=0 that cycle → rd=7 written, then pipe_hold=0.
- In FORCE, drive pipe_wr_en=1 → pipeline write appears on the rf_* outputs, err=1 and stays 1, state remains FORCE until a cycle with pipe_wr_en=0.
- Issue rd=0, then LU result rd=0 → busy stays 0, stall=0 for chk_rs1=0, drain writes rf_rd=0, no deadlock.
- Buffer full with busy[9]=1; assert reset asynchronously mid-cycle → buf_valid=0, busy=0, pipe_hold=0 immediately, without waiting for a clock edge.
